// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: parametrised VGA timing and RGB565 test-pattern generator.
// Ports:
//   clk_pll      pixel clock, all logic on its rising edge
//   rst_n        asynchronous active-low reset
//   mode_i[1:0]  pattern select, loaded only on the last pixel of a frame
//   HSYNC/VSYNC  syncs, asserted level set by H_SYNC_POL / V_SYNC_POL
//   DE           high during active video
//   frame_start  one-cycle pulse with pixel (0,0)
//   RED_OUT[4:0], GREEN_OUT[5:0], BLUE_OUT[4:0]  RGB565 pixel
// Optional feature: define VGA_SCROLL_EN to scroll the colour bars left one
// pixel per frame; without it the bars are static and no scroll logic exists.
module vga_pattern_gen #(
  parameter int unsigned H_PIXELS          = 640,
  parameter int unsigned H_FRONTPORCH      = 16,
  parameter int unsigned H_SYNCTIME        = 96,
  parameter int unsigned H_BACKPORCH       = 48,
  parameter int unsigned V_LINES           = 480,
  parameter int unsigned V_FRONTPORCH      = 10,
  parameter int unsigned V_SYNCTIME        = 2,
  parameter int unsigned V_BACKPORCH       = 33,
  parameter logic        H_SYNC_POL        = 1'b0,
  parameter logic        V_SYNC_POL        = 1'b0,
  parameter int unsigned NUMBER_OF_COLUMNS = 8,
  parameter int unsigned CHECKER_LOG2      = 5
) (
  input  logic       clk_pll,
  input  logic       rst_n,
  input  logic [1:0] mode_i,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       DE,
  output logic       frame_start,
  output logic [4:0] RED_OUT,
  output logic [5:0] GREEN_OUT,
  output logic [4:0] BLUE_OUT
);

  localparam int unsigned H_TOTAL  = H_PIXELS + H_FRONTPORCH + H_SYNCTIME + H_BACKPORCH;
  localparam int unsigned V_TOTAL  = V_LINES + V_FRONTPORCH + V_SYNCTIME + V_BACKPORCH;
  localparam int unsigned HW       = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int unsigned VW       = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int unsigned HS_START = H_PIXELS + H_FRONTPORCH;
  localparam int unsigned HS_END   = HS_START + H_SYNCTIME;
  localparam int unsigned VS_START = V_LINES + V_FRONTPORCH;
  localparam int unsigned VS_END   = VS_START + V_SYNCTIME;
  localparam int unsigned BW       = H_PIXELS / NUMBER_OF_COLUMNS;
  localparam int unsigned LAST_COL = NUMBER_OF_COLUMNS - 1;
  localparam int unsigned CW       = (NUMBER_OF_COLUMNS > 1) ? $clog2(NUMBER_OF_COLUMNS) : 1;
  localparam int unsigned PW       = (BW > 1) ? $clog2(BW) : 1;

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic [CW-1:0] col_q, col_d;
  logic [PW-1:0] ph_q, ph_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          de_q, de_d, fs_q, fs_d;
  logic [4:0]    red_q, red_d, blue_q, blue_d;
  logic [5:0]    green_q, green_d;
  logic          line_end, frame_end, active;
  logic [2:0]    bar_idx;

`ifdef VGA_SCROLL_EN
  localparam int unsigned XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  logic [XW-1:0] x_q, x_d, st_x_q, st_x_d;
  logic [CW-1:0] st_col_q, st_col_d;
  logic [PW-1:0] st_ph_q, st_ph_d;

  // Effective-x advance, wrapping at the end of the active width.
  function automatic logic [XW-1:0] x_step(input logic [XW-1:0] x);
    return (32'(x) == H_PIXELS - 1) ? '0 : x + XW'(1);
  endfunction
`endif

  // Bar-phase advance: phase wraps every BW pixels, column saturates at the last bar.
  function automatic logic [PW-1:0] ph_step(input logic [PW-1:0] ph);
    return (32'(ph) == BW - 1) ? '0 : ph + PW'(1);
  endfunction

  function automatic logic [CW-1:0] col_step(input logic [CW-1:0] col,
                                             input logic [PW-1:0] ph);
    return ((32'(ph) == BW - 1) && (32'(col) != LAST_COL)) ? col + CW'(1) : col;
  endfunction

  // Next-state: raster counters, frame counter, mode, bar tracking and pixel outputs.
  always_comb begin
    h_cnt_d     = h_cnt_q + HW'(1);
    v_cnt_d     = v_cnt_q;
    frame_cnt_d = frame_cnt_q;
    mode_d      = mode_q;
    line_end    = (32'(h_cnt_q) == H_TOTAL - 1);
    frame_end   = line_end && (32'(v_cnt_q) == V_TOTAL - 1);

    if (line_end) begin
      h_cnt_d = '0;
      v_cnt_d = frame_end ? '0 : v_cnt_q + VW'(1);
    end
    if (frame_end) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
      mode_d      = mode_i;
    end

`ifdef VGA_SCROLL_EN
    st_x_d   = st_x_q;
    st_col_d = st_col_q;
    st_ph_d  = st_ph_q;
    x_d      = x_step(x_q);
    col_d    = col_step(col_q, ph_q);
    ph_d     = ph_step(ph_q);
    if (32'(x_q) == H_PIXELS - 1) begin
      col_d = '0;
      ph_d  = '0;
    end
    // Line start position moves one pixel per frame, back to 0 when frame_cnt wraps.
    if (frame_end) begin
      if (frame_cnt_d == 8'd0) begin
        st_x_d   = '0;
        st_col_d = '0;
        st_ph_d  = '0;
      end else begin
        st_x_d   = x_step(st_x_q);
        st_col_d = col_step(st_col_q, st_ph_q);
        st_ph_d  = ph_step(st_ph_q);
        if (32'(st_x_q) == H_PIXELS - 1) begin
          st_col_d = '0;
          st_ph_d  = '0;
        end
      end
      x_d   = st_x_d;
      col_d = st_col_d;
      ph_d  = st_ph_d;
    end else if (line_end) begin
      x_d   = st_x_q;
      col_d = st_col_q;
      ph_d  = st_ph_q;
    end
`else
    col_d = col_step(col_q, ph_q);
    ph_d  = ph_step(ph_q);
    if (line_end) begin
      col_d = '0;
      ph_d  = '0;
    end
`endif

    active  = (32'(h_cnt_q) < H_PIXELS) && (32'(v_cnt_q) < V_LINES);
    hsync_d = ((32'(h_cnt_q) >= HS_START) && (32'(h_cnt_q) < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_d = ((32'(v_cnt_q) >= VS_START) && (32'(v_cnt_q) < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
    de_d    = active;
    fs_d    = (h_cnt_q == '0) && (v_cnt_q == '0);
    bar_idx = 3'(col_q);
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;

    if (active) begin
      case (mode_q)
        // Bar colours white..black: each channel is one inverted index bit.
        2'd0: begin
          red_d   = {5{~bar_idx[1]}};
          green_d = {6{~bar_idx[2]}};
          blue_d  = {5{~bar_idx[0]}};
        end
        2'd1: begin
          if (1'(h_cnt_q >> CHECKER_LOG2) ^ 1'(v_cnt_q >> CHECKER_LOG2)) begin
            red_d   = 5'd31;
            green_d = 6'd63;
            blue_d  = 5'd31;
          end
        end
        2'd2: begin
          red_d   = 5'(h_cnt_q >> 4);
          green_d = 6'(h_cnt_q >> 3);
          blue_d  = 5'(h_cnt_q >> 4);
        end
        default: begin
          red_d   = frame_cnt_q[7:3];
          green_d = frame_cnt_q[7:2];
          blue_d  = ~frame_cnt_q[7:3];
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk_pll or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      frame_cnt_q <= '0;
      mode_q      <= '0;
      col_q       <= '0;
      ph_q        <= '0;
      hsync_q     <= ~H_SYNC_POL;
      vsync_q     <= ~V_SYNC_POL;
      de_q        <= 1'b0;
      fs_q        <= 1'b0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
`ifdef VGA_SCROLL_EN
      x_q         <= '0;
      st_x_q      <= '0;
      st_col_q    <= '0;
      st_ph_q     <= '0;
`endif
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      mode_q      <= mode_d;
      col_q       <= col_d;
      ph_q        <= ph_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      fs_q        <= fs_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
`ifdef VGA_SCROLL_EN
      x_q         <= x_d;
      st_x_q      <= st_x_d;
      st_col_q    <= st_col_d;
      st_ph_q     <= st_ph_d;
`endif
    end
  end

  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign DE          = de_q;
  assign frame_start = fs_q;
  assign RED_OUT     = red_q;
  assign GREEN_OUT   = green_q;
  assign BLUE_OUT    = blue_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: two small-geometry instances of vga_pattern_gen checked
// every cycle against a frame/line/pixel arithmetic model, plus literal pins.
//   dut_a: 20 px (3 bars, BW=6), active-low syncs, 32x7 raster.
//   dut_b: 40 px (8 bars, BW=5), active-high syncs, 56x48 raster, 32-px checker.
module tb_vga_pattern_gen;

  typedef struct {
    int   hp, hfp, hs, hbp, vl, vfp, vs, vbp, nc, cl;
    logic hpol, vpol;
  } cfg_t;

  localparam int A_HP = 20, A_HFP = 4, A_HS = 6, A_HBP = 2;
  localparam int A_VL = 4, A_VFP = 1, A_VS = 1, A_VBP = 1, A_NC = 3, A_CL = 1;
  localparam int B_HP = 40, B_HFP = 4, B_HS = 8, B_HBP = 4;
  localparam int B_VL = 40, B_VFP = 2, B_VS = 3, B_VBP = 3, B_NC = 8, B_CL = 5;

`ifdef VGA_SCROLL_EN
  localparam logic [15:0] A_F1X5 = {5'd31, 6'd63, 5'd0};
`else
  localparam logic [15:0] A_F1X5 = {5'd31, 6'd63, 5'd31};
`endif

  logic       clk_pll = 1'b0;
  logic       rst_n   = 1'b0;
  logic [1:0] mode_i  = 2'd0;
  logic       a_hs, a_vs, a_de, a_fs, b_hs, b_vs, b_de, b_fs;
  logic [4:0] a_r, a_b, b_r, b_b;
  logic [5:0] a_g, b_g;

  always #5 clk_pll = ~clk_pll;

  vga_pattern_gen #(
    .H_PIXELS(A_HP), .H_FRONTPORCH(A_HFP), .H_SYNCTIME(A_HS), .H_BACKPORCH(A_HBP),
    .V_LINES(A_VL), .V_FRONTPORCH(A_VFP), .V_SYNCTIME(A_VS), .V_BACKPORCH(A_VBP),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .NUMBER_OF_COLUMNS(A_NC), .CHECKER_LOG2(A_CL)
  ) dut_a (
    .clk_pll(clk_pll), .rst_n(rst_n), .mode_i(mode_i),
    .HSYNC(a_hs), .VSYNC(a_vs), .DE(a_de), .frame_start(a_fs),
    .RED_OUT(a_r), .GREEN_OUT(a_g), .BLUE_OUT(a_b)
  );

  vga_pattern_gen #(
    .H_PIXELS(B_HP), .H_FRONTPORCH(B_HFP), .H_SYNCTIME(B_HS), .H_BACKPORCH(B_HBP),
    .V_LINES(B_VL), .V_FRONTPORCH(B_VFP), .V_SYNCTIME(B_VS), .V_BACKPORCH(B_VBP),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .NUMBER_OF_COLUMNS(B_NC), .CHECKER_LOG2(B_CL)
  ) dut_b (
    .clk_pll(clk_pll), .rst_n(rst_n), .mode_i(mode_i),
    .HSYNC(b_hs), .VSYNC(b_vs), .DE(b_de), .frame_start(b_fs),
    .RED_OUT(b_r), .GREEN_OUT(b_g), .BLUE_OUT(b_b)
  );

  cfg_t cfg_a, cfg_b;
  int   n_tests = 0, n_fail = 0;
  int   n;          // rising edges since reset release
  int   sched;      // 0: mode_i=0, 1: mode_i=1, 2: random
  bit   pins_on, post_rst;
  int   mode_cur_a, mode_nxt_a, mode_cur_b, mode_nxt_b;
  int   cnt_hs, cnt_vs, cnt_de, cnt_fs;

  int bar_r [8] = '{31, 31, 0, 0, 31, 31, 0, 0};
  int bar_g [8] = '{63, 63, 63, 63, 0, 0, 0, 0};
  int bar_b [8] = '{31, 0, 31, 0, 31, 0, 31, 0};

  function automatic int ht_of(input cfg_t c);
    return c.hp + c.hfp + c.hs + c.hbp;
  endfunction

  function automatic int ft_of(input cfg_t c);
    return ht_of(c) * (c.vl + c.vfp + c.vs + c.vbp);
  endfunction

  function automatic int pix_h(input cfg_t c, input int p);
    return (p % ft_of(c)) % ht_of(c);
  endfunction

  function automatic int pix_v(input cfg_t c, input int p);
    return (p % ft_of(c)) / ht_of(c);
  endfunction

  function automatic int pix_f(input cfg_t c, input int p);
    return p / ft_of(c);
  endfunction

  // Expected {HSYNC,VSYNC,DE,frame_start,R,G,B} for the p-th output cycle after reset.
  function automatic logic [19:0] model(input cfg_t c, input int p, input int mode);
    int   h, v, fc, x, k, r, g, b;
    logic act, hs, vs, fs;
    h   = pix_h(c, p);
    v   = pix_v(c, p);
    fc  = pix_f(c, p) % 256;
    act = (h < c.hp) && (v < c.vl);
    hs  = (h >= c.hp + c.hfp && h < c.hp + c.hfp + c.hs) ? c.hpol : ~c.hpol;
    vs  = (v >= c.vl + c.vfp && v < c.vl + c.vfp + c.vs) ? c.vpol : ~c.vpol;
    fs  = (h == 0) && (v == 0);
    r = 0; g = 0; b = 0;
    if (act) begin
      case (mode)
        0: begin
          x = h;
`ifdef VGA_SCROLL_EN
          x = (h + fc) % c.hp;
`endif
          k = x / (c.hp / c.nc);
          if (k > c.nc - 1) k = c.nc - 1;
          r = bar_r[k % 8]; g = bar_g[k % 8]; b = bar_b[k % 8];
        end
        1: if (((h >> c.cl) & 1) != ((v >> c.cl) & 1)) begin r = 31; g = 63; b = 31; end
        2: begin r = (h >> 4) % 32; g = (h >> 3) % 64; b = r; end
        default: begin r = fc / 8; g = fc / 4; b = 31 - fc / 8; end
      endcase
    end
    return {hs, vs, act, fs, 5'(r), 6'(g), 5'(b)};
  endfunction

  task automatic chk(input string name, input int p, input logic [19:0] act,
                     input logic [19:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s p=%0d got=%h expected=%h", name, p, act, exp);
    end
  endtask

  // One pixel clock: compare both DUTs against the model, then drive mode_i.
  task automatic run_cycle();
    int p;
    @(posedge clk_pll);
    n++;
    @(negedge clk_pll);
    p = n - 1;
    if (pix_h(cfg_a, p) == 0 && pix_v(cfg_a, p) == 0) mode_cur_a = (p == 0) ? 0 : mode_nxt_a;
    if (pix_h(cfg_b, p) == 0 && pix_v(cfg_b, p) == 0) mode_cur_b = (p == 0) ? 0 : mode_nxt_b;
    chk("pix_a", p, {a_hs, a_vs, a_de, a_fs, a_r, a_g, a_b}, model(cfg_a, p, mode_cur_a));
    chk("pix_b", p, {b_hs, b_vs, b_de, b_fs, b_r, b_g, b_b}, model(cfg_b, p, mode_cur_b));

    if (pins_on) begin
      if (p < 4 * ft_of(cfg_a)) begin
        cnt_hs += (a_hs == 1'b0) ? 1 : 0;
        cnt_vs += (a_vs == 1'b0) ? 1 : 0;
        cnt_de += a_de ? 1 : 0;
        cnt_fs += a_fs ? 1 : 0;
      end
      if (pix_f(cfg_a, p) == 0 && pix_v(cfg_a, p) == 0) begin
        case (pix_h(cfg_a, p))
          0:  chk("a_f0_x0_white", p, 20'({a_de, a_fs, a_r, a_g, a_b}), 20'({2'b11, 5'd31, 6'd63, 5'd31}));
          6:  chk("a_f0_x6_yellow", p, 20'({a_r, a_g, a_b}), 20'({5'd31, 6'd63, 5'd0}));
          12: chk("a_f0_x12_cyan", p, 20'({a_r, a_g, a_b}), 20'({5'd0, 6'd63, 5'd31}));
          19: chk("a_f0_x19_cyan", p, 20'({a_r, a_g, a_b}), 20'({5'd0, 6'd63, 5'd31}));
          default: ;
        endcase
      end
      if (pix_f(cfg_a, p) == 1 && pix_v(cfg_a, p) == 0 && pix_h(cfg_a, p) == 5)
        chk("a_f1_x5", p, 20'({a_r, a_g, a_b}), 20'(A_F1X5));
      if (pix_f(cfg_b, p) == 0 && pix_v(cfg_b, p) == 35 && pix_h(cfg_b, p) == 32)
        chk("b_f0_late_bars_blue", p, 20'({b_de, b_r, b_g, b_b}), 20'({1'b1, 5'd0, 6'd0, 5'd31}));
      if (pix_f(cfg_b, p) == 1 && pix_h(cfg_b, p) == 32) begin
        if (pix_v(cfg_b, p) == 0)
          chk("b_chk_32_0_white", p, 20'({b_r, b_g, b_b}), 20'({5'd31, 6'd63, 5'd31}));
        if (pix_v(cfg_b, p) == 32)
          chk("b_chk_32_32_black", p, 20'({b_de, b_r, b_g, b_b}), 20'({1'b1, 16'd0}));
      end
    end
    if (post_rst && p == 0)
      chk("fs_after_rst", p, 20'({a_fs, a_de, b_fs, b_de}), 20'(4'hf));

    if ((p % ft_of(cfg_a)) == ft_of(cfg_a) - 1) mode_nxt_a = int'(mode_i);
    if ((p % ft_of(cfg_b)) == ft_of(cfg_b) - 1) mode_nxt_b = int'(mode_i);
    case (sched)
      0:       mode_i = 2'd0;
      1:       mode_i = 2'd1;
      default: mode_i = 2'($urandom_range(0, 3));
    endcase
  endtask

  initial begin
    bit found;
    cfg_a = '{A_HP, A_HFP, A_HS, A_HBP, A_VL, A_VFP, A_VS, A_VBP, A_NC, A_CL, 1'b0, 1'b0};
    cfg_b = '{B_HP, B_HFP, B_HS, B_HBP, B_VL, B_VFP, B_VS, B_VBP, B_NC, B_CL, 1'b1, 1'b1};
    n = 0; sched = 0; pins_on = 0; post_rst = 0; found = 0;
    mode_cur_a = 0; mode_nxt_a = 0; mode_cur_b = 0; mode_nxt_b = 0;
    cnt_hs = 0; cnt_vs = 0; cnt_de = 0; cnt_fs = 0;

    repeat (2) @(posedge clk_pll);
    @(negedge clk_pll);
    chk("rst_a_outputs", 0, {a_hs, a_vs, a_de, a_fs, a_r, a_g, a_b}, {2'b11, 18'd0});
    chk("rst_b_outputs", 0, {b_hs, b_vs, b_de, b_fs, b_r, b_g, b_b}, 20'd0);
    rst_n = 1'b1;

    pins_on = 1;
    for (int i = 0; i < 60000; i++) begin
      sched = (i < 1344) ? 0 : ((i < 5600) ? 1 : 2);
      run_cycle();
    end
    pins_on = 0;
    chk("a_hsync_cycles_4f", 0, 20'(cnt_hs), 20'd168);
    chk("a_vsync_cycles_4f", 0, 20'(cnt_vs), 20'd128);
    chk("a_de_cycles_4f", 0, 20'(cnt_de), 20'd320);
    chk("a_fs_pulses_4f", 0, 20'(cnt_fs), 20'd4);

    // Reset mid-frame while dut_b is showing active pixel (10,20).
    for (int i = 0; i < 3000 && !found; i++) begin
      run_cycle();
      if (pix_h(cfg_b, n - 1) == 10 && pix_v(cfg_b, n - 1) == 20) found = 1;
    end
    if (!found) chk("rst_search_timeout", 0, 20'd0, 20'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_a", 0, {a_hs, a_vs, a_de, a_fs, a_r, a_g, a_b}, {2'b11, 18'd0});
    chk("midrst_b", 0, {b_hs, b_vs, b_de, b_fs, b_r, b_g, b_b}, 20'd0);
    @(posedge clk_pll);
    #1 chk("midrst_b_held", 0, {b_hs, b_vs, b_de, b_fs, b_r, b_g, b_b}, 20'd0);
    @(negedge clk_pll);
    rst_n = 1'b1;
    n = 0; mode_cur_a = 0; mode_cur_b = 0;
    post_rst = 1;
    for (int i = 0; i < 3000; i++) run_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
